// File: rtl/bit_ser_feed.sv
// bit_ser_feed: operand serializer feeding the bit-serial adder stage.
//
// Accepts a parallel operand pair (op_a/op_b) on in_valid & in_ready, then
// drives the adder control sequence:
//   CLEAR: add_clr_n low for 1 cycle
//   SHIFT: WIDTH cycles of serial bits on ser_a/ser_b
//   RUN  : add_set_n low for RUN_CYCLES cycles
//   DONE : done high for 1 cycle (adder result valid to sample)
// All outputs are registered from the next-state logic, so no input reaches
// an output combinationally.
//
// Ports:
//   clk, clr_n      clock, asynchronous active-low reset
//   in_valid/ready  operand pair handshake (ready only while idle)
//   op_a, op_b      parallel operands, latched on accept
//   ser_a, ser_b    serial operand bits to the adder
//   add_clr_n       active-low adder clear
//   add_set_n       active-low adder run
//   busy            high outside IDLE
//   done            one-cycle end-of-run pulse
//
// Build option: define BIT_SER_FEED_MSB_FIRST_EN to shift MSB-first
// (default is LSB-first, which is what the adder expects).
module bit_ser_feed #(
    parameter int WIDTH      = 8,
    parameter int RUN_CYCLES = 9
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             ser_a,
    output logic             ser_b,
    output logic             add_clr_n,
    output logic             add_set_n,
    output logic             busy,
    output logic             done
);

    localparam int MAXC = (WIDTH > RUN_CYCLES) ? WIDTH : RUN_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] SHIFT_LOAD = CW'(WIDTH - 1);
    localparam logic [CW-1:0] RUN_LOAD   = CW'(RUN_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] sh_a, sh_b, sh_a_nxt, sh_b_nxt;
    logic [WIDTH-1:0] sh_a_adv, sh_b_adv;
    logic             bit_a, bit_b;
    logic             ser_a_nxt, ser_b_nxt, clr_n_nxt, set_n_nxt;
    logic             ready_nxt, done_nxt, busy_nxt;

    // Bit presented this cycle and the shift register after consuming it.
`ifdef BIT_SER_FEED_MSB_FIRST_EN
    assign bit_a    = sh_a[WIDTH-1];
    assign bit_b    = sh_b[WIDTH-1];
    assign sh_a_adv = sh_a << 1;
    assign sh_b_adv = sh_b << 1;
`else
    assign bit_a    = sh_a[0];
    assign bit_b    = sh_b[0];
    assign sh_a_adv = sh_a >> 1;
    assign sh_b_adv = sh_b >> 1;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sh_a_nxt  = sh_a;
        sh_b_nxt  = sh_b;
        ser_a_nxt = 1'b0;
        ser_b_nxt = 1'b0;
        clr_n_nxt = 1'b1;
        set_n_nxt = 1'b1;
        ready_nxt = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                // in_ready is the registered flag, so the first cycle after
                // reset release cannot accept even though state is IDLE.
                if (in_valid && in_ready) begin
                    state_nxt = CLEAR;
                    sh_a_nxt  = op_a;
                    sh_b_nxt  = op_b;
                    clr_n_nxt = 1'b0;
                end else begin
                    ready_nxt = 1'b1;
                end
            end
            CLEAR: begin
                // Leaving CLEAR already presents serial bit 0.
                state_nxt = SHIFT;
                cnt_nxt   = SHIFT_LOAD;
                ser_a_nxt = bit_a;
                ser_b_nxt = bit_b;
                sh_a_nxt  = sh_a_adv;
                sh_b_nxt  = sh_b_adv;
            end
            SHIFT: begin
                if (cnt == '0) begin
                    state_nxt = RUN;
                    cnt_nxt   = RUN_LOAD;
                    set_n_nxt = 1'b0;
                end else begin
                    cnt_nxt   = cnt - 1'b1;
                    ser_a_nxt = bit_a;
                    ser_b_nxt = bit_b;
                    sh_a_nxt  = sh_a_adv;
                    sh_b_nxt  = sh_b_adv;
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt   = cnt - 1'b1;
                    set_n_nxt = 1'b0;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                ready_nxt = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state     <= IDLE;
            cnt       <= '0;
            sh_a      <= '0;
            sh_b      <= '0;
            ser_a     <= 1'b0;
            ser_b     <= 1'b0;
            add_clr_n <= 1'b0;
            add_set_n <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            sh_a      <= sh_a_nxt;
            sh_b      <= sh_b_nxt;
            ser_a     <= ser_a_nxt;
            ser_b     <= ser_b_nxt;
            add_clr_n <= clr_n_nxt;
            add_set_n <= set_n_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            in_ready  <= ready_nxt;
        end
    end

endmodule

// File: tb/tb_bit_ser_feed.sv
// Bench for bit_ser_feed: timeline model (cycles since accept) checked every
// cycle, plus literal stream / latency / adder-sum expectations per test.
module tb_bit_ser_feed;

    localparam int W    = 8;
    localparam int R    = 9;
    localparam int LAST = W + R + 2;   // cycle index of the done pulse

    logic         clk = 1'b0;
    logic         clr_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         in_ready, ser_a, ser_b, add_clr_n, add_set_n, busy, done;

    always #5 clk = ~clk;

    bit_ser_feed #(.WIDTH(W), .RUN_CYCLES(R)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .ser_a     (ser_a),
        .ser_b     (ser_b),
        .add_clr_n (add_clr_n),
        .add_set_n (add_set_n),
        .busy      (busy),
        .done      (done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: t = -2 just out of reset, -1 idle & ready, 1..LAST cycles since accept.
    int           t = -2;
    logic [W-1:0] ma = '0;
    logic [W-1:0] mb = '0;

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n)       t <= -2;
        else if (t == -2) t <= -1;
        else if (t == -1) begin
            if (in_valid) begin
                t  <= 1;
                ma <= op_a;
                mb <= op_b;
            end
        end
        else if (t == LAST) t <= -1;
        else                t <= t + 1;
    end

    // {in_ready, busy, done, add_clr_n, add_set_n, ser_a, ser_b}
    function automatic logic [6:0] model_out(int tt, logic [W-1:0] a, logic [W-1:0] b);
        logic sa, sb;
        int   k;
        sa = 1'b0;
        sb = 1'b0;
        if (tt >= 2 && tt <= W + 1) begin
`ifdef BIT_SER_FEED_MSB_FIRST_EN
            k = W - 1 - (tt - 2);
`else
            k = tt - 2;
`endif
            sa = a[k];
            sb = b[k];
        end
        return {tt == -1, tt >= 1, tt == LAST, !(tt == -2 || tt == 1),
                !(tt >= W + 2 && tt <= W + R + 1), sa, sb};
    endfunction

    function automatic logic [W-1:0] rev(logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[W-1-i];
        return r;
    endfunction

    logic         chk_en = 1'b0;
    logic [W-1:0] cap_a = '0;
    logic [W-1:0] cap_b = '0;
    int           n_done = 0;

    always @(negedge clk) begin
        logic [6:0] exp_v, act_v;
        if (chk_en) begin
            exp_v = model_out(t, ma, mb);
            act_v = {in_ready, busy, done, add_clr_n, add_set_n, ser_a, ser_b};
            n_tests++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL cycle_outputs t=%0d got %b want %b", t, act_v, exp_v);
            end
            if (t == 1) begin
                cap_a = '0;
                cap_b = '0;
            end
            if (t >= 2 && t <= W + 1) begin
                cap_a[t-2] = ser_a;
                cap_b[t-2] = ser_b;
            end
            if (done) n_done++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    // One operand pair; streams given as bit k = serial cycle k.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int chg_at,
                          input logic [W-1:0] exp_sa, input logic [W-1:0] exp_sb,
                          input int exp_sum);
        int n;
        int sum;
        @(negedge clk);
        op_a = a;
        op_b = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!done && n < 40) begin
            if (n == chg_at) begin
                op_a = ~a;
                op_b = ~b;
            end
            @(negedge clk);
            n++;
        end
        chk("latency", n, 19);
        chk("stream_a", int'(cap_a), int'(exp_sa));
        chk("stream_b", int'(cap_b), int'(exp_sb));
`ifdef BIT_SER_FEED_MSB_FIRST_EN
        sum = int'(rev(cap_a)) + int'(rev(cap_b));
`else
        sum = int'(cap_a) + int'(cap_b);
`endif
        chk("adder_result", sum, exp_sum);
    endtask

    initial begin
        int d0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_outputs", int'({in_ready, busy, done, add_clr_n, add_set_n, ser_a, ser_b}),
            int'(7'b0000100));
        clr_n = 1'b1;
        @(negedge clk);
        chk("first_edge_ready", int'({in_ready, add_clr_n}), 3);

`ifdef BIT_SER_FEED_MSB_FIRST_EN
        run_op(8'd7, 8'd3, 0, 8'hE0, 8'hC0, 10);
        run_op(8'd6, 8'd4, 0, 8'h60, 8'h20, 10);
        run_op(8'hA5, 8'h3C, 4, 8'hA5, 8'h3C, 225);
        run_op(8'h81, 8'h40, 0, 8'h81, 8'h02, 193);
`else
        run_op(8'd7, 8'd3, 0, 8'h07, 8'h03, 10);
        run_op(8'd6, 8'd4, 0, 8'h06, 8'h04, 10);
        run_op(8'hA5, 8'h3C, 4, 8'hA5, 8'h3C, 225);
        run_op(8'h81, 8'h40, 0, 8'h81, 8'h40, 193);
`endif

        // Continuous in_valid: one accept every 20 cycles, 3 done pulses in 60.
        @(negedge clk);
        op_a = 8'd255;
        op_b = 8'd1;
        in_valid = 1'b1;
        d0 = n_done;
        repeat (60) @(negedge clk);
        in_valid = 1'b0;
        chk("hold_valid_dones", n_done - d0, 3);
        repeat (20) @(negedge clk);

        // Reset during SHIFT cycle 3.
        op_a = 8'd7;
        op_b = 8'd3;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 clr_n = 1'b0;
        #1 chk("midop_reset_outputs",
               int'({in_ready, busy, done, add_clr_n, add_set_n, ser_a, ser_b}),
               int'(7'b0000100));
        d0 = n_done;
        repeat (3) @(negedge clk);
        chk("midop_reset_no_done", n_done - d0, 0);
        clr_n = 1'b1;
`ifdef BIT_SER_FEED_MSB_FIRST_EN
        run_op(8'd7, 8'd3, 0, 8'hE0, 8'hC0, 10);
`else
        run_op(8'd7, 8'd3, 0, 8'h07, 8'h03, 10);
`endif
        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
